swi_source_mux: RTL and testbench

Switch-input conditioning stage directly downstream of the virtual-JTAG debug interface. It takes the 8-bit switch word written over JTAG and the physical board switches, and synchronizes both into the `clk_2` domain. The JTAG word changes on the JTAG update strobe, asynchronously to `clk_2`. Each source is stability-filtered, and a last-writer-wins arbiter picks which source drives the `SWI` bus seen by the student design. One-cycle rise and fall pulses are produced per bit so that the design under test can single-step from either source.

---
 rtl/swi_pkg.sv | 13 +
 rtl/swi_filter.sv | 64 ++++++
 rtl/swi_source_mux.sv | 84 ++++++++
 tb/tb_swi_source_mux.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/swi_pkg.sv
// Shared types and default sizing for the switch-input conditioning stage.
package swi_pkg;

    typedef enum logic {
        OWN_PHYS = 1'b0,
        OWN_JTAG = 1'b1
    } owner_t;

    localparam int SWI_NSWI_DEF        = 8;
    localparam int SWI_SYNC_STAGES_DEF = 2;
    localparam int SWI_DEB_CYCLES_DEF  = 4;

endpackage

// File: rtl/swi_filter.sv
// One switch source: flop synchronizer, whole-word stability filter, accepted register.
// accepted/changed are the values being registered at this edge so the arbiter can act in the same cycle.
module swi_filter
    import swi_pkg::*;
#(
    parameter int NSWI        = SWI_NSWI_DEF,
    parameter int SYNC_STAGES = SWI_SYNC_STAGES_DEF,
    parameter int DEB_CYCLES  = SWI_DEB_CYCLES_DEF
) (
    input  logic            clk_2,
    input  logic            reset,
    input  logic [NSWI-1:0] swi_async,
    output logic [NSWI-1:0] accepted,
    output logic            changed
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DEB_CYCLES);

    logic [SYNC_STAGES-1:0][NSWI-1:0] sync_q, sync_d;
    logic [NSWI-1:0] synced;
    logic [NSWI-1:0] cand_q, cand_d;
    logic [NSWI-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], swi_async};
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        changed = 1'b0;
        if (synced != cand_q) begin
            cand_d = synced;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Counter parks at CNT_SAT so a held word is accepted only once.
            acc_d   = cand_q;
            cnt_d   = CNT_SAT;
            changed = (cand_q != acc_q);
        end else if (cnt_q < CNT_LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

    assign accepted = acc_d;

endmodule

// File: rtl/swi_source_mux.sv
// Picks the physical or JTAG switch word (last writer wins, physical on ties),
// registers it as SWI and produces one-cycle rise/fall pulses per bit.
module swi_source_mux
    import swi_pkg::*;
#(
    parameter int NSWI        = SWI_NSWI_DEF,
    parameter int SYNC_STAGES = SWI_SYNC_STAGES_DEF,
    parameter int DEB_CYCLES  = SWI_DEB_CYCLES_DEF
) (
    input  logic            clk_2,
    input  logic            reset,
    input  logic [NSWI-1:0] swi_phys,
    input  logic [NSWI-1:0] swi_jtag,
    output logic [NSWI-1:0] SWI,
    output logic [NSWI-1:0] swi_rise,
    output logic [NSWI-1:0] swi_fall,
    output logic            owner_jtag
);

    logic [NSWI-1:0] phys_acc, jtag_acc;
    logic            phys_chg, jtag_chg;

    owner_t          state_q, state_d;
    logic [NSWI-1:0] swi_q, swi_d;
    logic [NSWI-1:0] rise_q, rise_d;
    logic [NSWI-1:0] fall_q, fall_d;

    swi_filter #(
        .NSWI        (NSWI),
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_filt_phys (
        .clk_2     (clk_2),
        .reset     (reset),
        .swi_async (swi_phys),
        .accepted  (phys_acc),
        .changed   (phys_chg)
    );

    swi_filter #(
        .NSWI        (NSWI),
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_filt_jtag (
        .clk_2     (clk_2),
        .reset     (reset),
        .swi_async (swi_jtag),
        .accepted  (jtag_acc),
        .changed   (jtag_chg)
    );

    always_comb begin
        state_d = state_q;
        if (phys_chg) begin
            state_d = OWN_PHYS;
        end else if (jtag_chg) begin
            state_d = OWN_JTAG;
        end
        // Follow the next-state owner so ownership and value move together.
        swi_d  = (state_d == OWN_JTAG) ? jtag_acc : phys_acc;
        rise_d = swi_d & ~swi_q;
        fall_d = ~swi_d & swi_q;
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= OWN_PHYS;
            swi_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            state_q <= state_d;
            swi_q   <= swi_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign SWI        = swi_q;
    assign swi_rise   = rise_q;
    assign swi_fall   = fall_q;
    assign owner_jtag = (state_q == OWN_JTAG);

endmodule

// File: tb/tb_swi_source_mux.sv
// Scenario bench for swi_source_mux: expected per-cycle outputs are queued with the stimulus
// and popped one per clock edge.
module tb_swi_source_mux;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [7:0] swi_phys;
    logic [7:0] swi_jtag;
    logic [7:0] SWI;
    logic [7:0] swi_rise;
    logic [7:0] swi_fall;
    logic       owner_jtag;

    typedef struct packed {
        logic [7:0] swi;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       own;
    } obs_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    swi_source_mux #(
        .NSWI        (8),
        .SYNC_STAGES (2),
        .DEB_CYCLES  (4)
    ) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .swi_phys   (swi_phys),
        .swi_jtag   (swi_jtag),
        .SWI        (SWI),
        .swi_rise   (swi_rise),
        .swi_fall   (swi_fall),
        .owner_jtag (owner_jtag)
    );

    always #5 clk_2 = ~clk_2;

    task automatic push_exp(input logic [7:0] s, input logic [7:0] r, input logic [7:0] f,
                            input logic o);
        sb.push_back({s, r, f, o});
    endtask

    // Expected trace for a single source change: old value for 6 edges, new value with
    // pulses at edge 7, then steady at edge 8.
    task automatic push_change(input logic [7:0] old_v, input logic old_o,
                               input logic [7:0] new_v, input logic new_o);
        repeat (6) push_exp(old_v, 8'h00, 8'h00, old_o);
        push_exp(new_v, new_v & ~old_v, ~new_v & old_v, new_o);
        push_exp(new_v, 8'h00, 8'h00, new_o);
    endtask

    task automatic settle();
        repeat (12) @(posedge clk_2);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, o;
        reset = 1'b1; swi_phys = 8'h00; swi_jtag = 8'h00;
        repeat (2) @(posedge clk_2);
        #1;
        reset = 1'b0;
        swi_phys = 8'hA5; swi_jtag = 8'h3C;
        push_change(8'h00, 1'b0, 8'hA5, 1'b0);
        for (int c = 1; sb.size() > 0; c++) begin
            @(posedge clk_2); #1;
            e = sb.pop_front(); o = {SWI, swi_rise, swi_fall, owner_jtag}; checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_first edge %0d: got swi=%h rise=%h fall=%h own=%b want swi=%h rise=%h fall=%h own=%b",
                         c, o.swi, o.rise, o.fall, o.own, e.swi, e.rise, e.fall, e.own);
            end
        end
        // Asynchronous assertion mid-cycle, then held for two edges.
        #3; reset = 1'b1; #1;
        repeat (3) push_exp(8'h00, 8'h00, 8'h00, 1'b0);
        for (int c = 0; sb.size() > 0; c++) begin
            if (c > 0) begin @(posedge clk_2); #1; end
            e = sb.pop_front(); o = {SWI, swi_rise, swi_fall, owner_jtag}; checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_held step %0d: got swi=%h rise=%h fall=%h own=%b want swi=%h rise=%h fall=%h own=%b",
                         c, o.swi, o.rise, o.fall, o.own, e.swi, e.rise, e.fall, e.own);
            end
        end
        reset = 1'b0;
        push_change(8'h00, 1'b0, 8'hA5, 1'b0);
        for (int c = 1; sb.size() > 0; c++) begin
            @(posedge clk_2); #1;
            e = sb.pop_front(); o = {SWI, swi_rise, swi_fall, owner_jtag}; checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_release edge %0d: got swi=%h rise=%h fall=%h own=%b want swi=%h rise=%h fall=%h own=%b",
                         c, o.swi, o.rise, o.fall, o.own, e.swi, e.rise, e.fall, e.own);
            end
        end
    endtask

    task automatic test_jtag_takeover();
        obs_t e, o;
        swi_phys = 8'h00; swi_jtag = 8'h00;
        settle();
        swi_jtag = 8'h01;
        push_change(8'h00, 1'b0, 8'h01, 1'b1);
        for (int c = 1; sb.size() > 0; c++) begin
            @(posedge clk_2); #1;
            e = sb.pop_front(); o = {SWI, swi_rise, swi_fall, owner_jtag}; checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL jtag_takeover edge %0d: got swi=%h rise=%h fall=%h own=%b want swi=%h rise=%h fall=%h own=%b",
                         c, o.swi, o.rise, o.fall, o.own, e.swi, e.rise, e.fall, e.own);
            end
        end
    endtask

    task automatic test_identical_write();
        obs_t e, o;
        swi_phys = 8'h02;
        push_change(8'h01, 1'b1, 8'h02, 1'b0);
        swi_jtag = 8'h01;
        repeat (10) push_exp(8'h02, 8'h00, 8'h00, 1'b0);
        for (int c = 1; sb.size() > 0; c++) begin
            @(posedge clk_2); #1;
            e = sb.pop_front(); o = {SWI, swi_rise, swi_fall, owner_jtag}; checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL identical_write edge %0d: got swi=%h rise=%h fall=%h own=%b want swi=%h rise=%h fall=%h own=%b",
                         c, o.swi, o.rise, o.fall, o.own, e.swi, e.rise, e.fall, e.own);
            end
        end
    endtask

    task automatic test_glitch();
        obs_t e, o;
        swi_phys = 8'h0A;
        repeat (12) push_exp(8'h02, 8'h00, 8'h00, 1'b0);
        for (int c = 1; sb.size() > 0; c++) begin
            @(posedge clk_2); #1;
            if (c == 3) swi_phys = 8'h02;
            e = sb.pop_front(); o = {SWI, swi_rise, swi_fall, owner_jtag}; checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL glitch edge %0d: got swi=%h rise=%h fall=%h own=%b want swi=%h rise=%h fall=%h own=%b",
                         c, o.swi, o.rise, o.fall, o.own, e.swi, e.rise, e.fall, e.own);
            end
        end
    endtask

    task automatic test_simultaneous();
        obs_t e, o;
        swi_phys = 8'h10; swi_jtag = 8'h20;
        push_change(8'h02, 1'b0, 8'h10, 1'b0);
        for (int c = 1; sb.size() > 0; c++) begin
            @(posedge clk_2); #1;
            e = sb.pop_front(); o = {SWI, swi_rise, swi_fall, owner_jtag}; checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL simultaneous edge %0d: got swi=%h rise=%h fall=%h own=%b want swi=%h rise=%h fall=%h own=%b",
                         c, o.swi, o.rise, o.fall, o.own, e.swi, e.rise, e.fall, e.own);
            end
        end
    endtask

    task automatic test_owner_switch();
        obs_t e, o;
        swi_phys = 8'h0F;
        settle();
        swi_jtag = 8'hF0;
        settle();
        push_exp(8'hF0, 8'h00, 8'h00, 1'b1);
        swi_phys = 8'h0E;
        push_change(8'hF0, 1'b1, 8'h0E, 1'b0);
        for (int c = 0; sb.size() > 0; c++) begin
            if (c > 0) begin @(posedge clk_2); #1; end
            e = sb.pop_front(); o = {SWI, swi_rise, swi_fall, owner_jtag}; checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL owner_switch edge %0d: got swi=%h rise=%h fall=%h own=%b want swi=%h rise=%h fall=%h own=%b",
                         c, o.swi, o.rise, o.fall, o.own, e.swi, e.rise, e.fall, e.own);
            end
        end
    endtask

    initial begin
        test_reset();
        test_jtag_takeover();
        test_identical_write();
        test_glitch();
        test_simultaneous();
        test_owner_switch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
